// File: rtl/checkers_move_engine.sv
`default_nettype none
// ============================================================================
// Module      : checkers_move_engine
// Description : Fixed-latency checkers move validator and board updater,
//               responder side of the start/done move handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module checkers_move_engine #(
    parameter int CELL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [64*CELL_W-1:0]  i_board_in,
    input  logic                  i_player_turn,
    input  logic [3:0]            i_x1,
    input  logic [3:0]            i_y1,
    input  logic [3:0]            i_x2,
    input  logic [3:0]            i_y2,
    output logic [64*CELL_W-1:0]  o_board_out,
    output logic                  o_next_turn,
    output logic                  o_done,
    output logic                  o_legal,
    output logic                  o_capture
);

    localparam int BW = 64 * CELL_W;

    localparam logic [CELL_W-1:0] c_EMPTY = 3'b111;
    localparam logic [CELL_W-1:0] c_P1M   = 3'b001;
    localparam logic [CELL_W-1:0] c_P2M   = 3'b010;
    localparam logic [CELL_W-1:0] c_P1K   = 3'b101;
    localparam logic [CELL_W-1:0] c_P2K   = 3'b110;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;

    logic [BW-1:0]           r_board;
    logic                    r_turn;
    logic [3:0]              r_x1, r_y1, r_x2, r_y2;
    logic signed [4:0]       r_dx, r_dy;
    logic [2:0]              r_mx, r_my;
    logic                    r_bad;
    logic [CELL_W-1:0]       r_src, r_dst, r_mid;
    logic                    r_legal_c, r_cap_c;
    logic [CELL_W-1:0]       r_land;

    logic [5:0]              w_src_idx, w_dst_idx, w_mid_idx;
    logic                    w_own, w_opp_mid, w_fwd, w_step, w_jump, w_legal, w_promote;
    logic [CELL_W-1:0]       w_land;
    logic [BW-1:0]           w_new_board;

    // Square (x,y) occupies the cell whose index is 8*y+x, counted from the MSB end.
    function automatic logic [CELL_W-1:0] cell_at(input logic [BW-1:0] b, input logic [5:0] idx);
        cell_at = b[BW-1 - CELL_W*int'(idx) -: CELL_W];
    endfunction

    assign w_src_idx = {r_y1[2:0], r_x1[2:0]};
    assign w_dst_idx = {r_y2[2:0], r_x2[2:0]};
    assign w_mid_idx = {r_my, r_mx};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = i_start ? S_LATCH : S_IDLE;
            S_LATCH: w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_done = (r_state == S_DONE);
    end

    // ---------------- Rule evaluation ----------------
    always_comb begin
        w_own     = r_turn ? (r_src == c_P1M || r_src == c_P1K)
                           : (r_src == c_P2M || r_src == c_P2K);
        w_opp_mid = r_turn ? (r_mid == c_P2M || r_mid == c_P2K)
                           : (r_mid == c_P1M || r_mid == c_P1K);
        // Bit 2 of an owned piece code marks a king, which may move either way.
        w_fwd     = r_src[2] | (r_turn ? r_dy[4] : ~r_dy[4]);
        w_step    = (r_dx == 5'sd1 || r_dx == -5'sd1) && (r_dy == 5'sd1 || r_dy == -5'sd1);
        w_jump    = (r_dx == 5'sd2 || r_dx == -5'sd2) && (r_dy == 5'sd2 || r_dy == -5'sd2)
                    && w_opp_mid;
        w_legal   = !r_bad && w_own && (r_dst == c_EMPTY) && w_fwd && (w_step || w_jump);
        w_promote = !r_src[2] && (r_turn ? (r_y2 == 4'd0) : (r_y2 == 4'd7));
        w_land    = w_promote ? (r_turn ? c_P1K : c_P2K) : r_src;
    end

    // ---------------- Board rewrite ----------------
    always_comb begin
        w_new_board = r_board;
        if (r_legal_c) begin
            w_new_board[BW-1 - CELL_W*int'(w_src_idx) -: CELL_W] = c_EMPTY;
            w_new_board[BW-1 - CELL_W*int'(w_dst_idx) -: CELL_W] = r_land;
            if (r_cap_c)
                w_new_board[BW-1 - CELL_W*int'(w_mid_idx) -: CELL_W] = c_EMPTY;
        end
    end

    // ---------------- Datapath pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board     <= '0;
            r_turn      <= 1'b0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_bad       <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_mid       <= '0;
            r_legal_c   <= 1'b0;
            r_cap_c     <= 1'b0;
            r_land      <= '0;
            o_board_out <= '0;
            o_next_turn <= 1'b1;
            o_legal     <= 1'b0;
            o_capture   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_board <= i_board_in;
                        r_turn  <= i_player_turn;
                        r_x1    <= i_x1;
                        r_y1    <= i_y1;
                        r_x2    <= i_x2;
                        r_y2    <= i_y2;
                    end
                end
                S_LATCH: begin
                    r_dx  <= $signed({1'b0, r_x2}) - $signed({1'b0, r_x1});
                    r_dy  <= $signed({1'b0, r_y2}) - $signed({1'b0, r_y1});
                    r_mx  <= 3'(({1'b0, r_x1[2:0]} + {1'b0, r_x2[2:0]}) >> 1);
                    r_my  <= 3'(({1'b0, r_y1[2:0]} + {1'b0, r_y2[2:0]}) >> 1);
                    r_bad <= r_x1[3] | r_y1[3] | r_x2[3] | r_y2[3]
                             | ((r_x1 == r_x2) && (r_y1 == r_y2));
                end
                S_FETCH: begin
                    r_src <= cell_at(r_board, w_src_idx);
                    r_dst <= cell_at(r_board, w_dst_idx);
                    r_mid <= cell_at(r_board, w_mid_idx);
                end
                S_CHECK: begin
                    r_legal_c <= w_legal;
                    r_cap_c   <= w_legal && w_jump;
                    r_land    <= w_land;
                end
                S_WRITE: begin
                    o_board_out <= w_new_board;
                    o_next_turn <= r_legal_c ? ~r_turn : r_turn;
                    o_legal     <= r_legal_c;
                    o_capture   <= r_cap_c;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_checkers_move_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_checkers_move_engine
// Description : Directed self-checking bench for checkers_move_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checkers_move_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [191:0] board_in = '0;
    logic         turn = 1'b0;
    logic [3:0]   x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [191:0] board_out;
    logic         next_turn, done, legal, capture;

    int n_chk = 0;
    int n_pass = 0;
    logic [191:0] init_b;

    checkers_move_engine #(.CELL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_board_in(board_in),
        .i_player_turn(turn), .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2),
        .o_board_out(board_out), .o_next_turn(next_turn), .o_done(done),
        .o_legal(legal), .o_capture(capture)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] setc(input logic [191:0] b, input int x, input int y,
                                          input logic [2:0] c);
        b[191 - 3*(8*y + x) -: 3] = c;
        return b;
    endfunction

    function automatic logic [191:0] make_init();
        logic [191:0] b = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (((x + y) % 2) == 1)
                    b = setc(b, x, y, (y < 3) ? 3'b010 : (y > 4) ? 3'b001 : 3'b111);
        return b;
    endfunction

    // Drive one request (start high for exactly one sampled edge), then scramble the
    // inputs and return the number of cycles until done (-1 if it never came).
    task automatic run_move(input logic [191:0] b, input logic t, input logic [3:0] a,
                            input logic [3:0] c, input logic [3:0] d, input logic [3:0] e,
                            output int lat);
        @(negedge clk);
        board_in = b; turn = t; x1 = a; y1 = c; x2 = d; y2 = e; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; board_in = '1; turn = ~t; x1 = 4'd3; y1 = 4'd3; x2 = 4'd4; y2 = 4'd4;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (board_out !== '0) $display("FAIL rst_board got %h exp 0", board_out); else n_pass++;
        n_chk++; if (next_turn !== 1'b1) $display("FAIL rst_turn got %b exp 1", next_turn); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_chk++; if (legal !== 1'b0) $display("FAIL rst_legal got %b exp 0", legal); else n_pass++;
        n_chk++; if (capture !== 1'b0) $display("FAIL rst_capture got %b exp 0", capture); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step_p1();
        int lat;
        logic [191:0] exp_b;
        exp_b = setc(setc(init_b, 0, 5, 3'b111), 1, 4, 3'b001);
        run_move(init_b, 1'b1, 4'd0, 4'd5, 4'd1, 4'd4, lat);
        n_chk++; if (lat !== 5) $display("FAIL t1_latency got %0d exp 5", lat); else n_pass++;
        n_chk++; if (legal !== 1'b1) $display("FAIL t1_legal got %b exp 1", legal); else n_pass++;
        n_chk++; if (capture !== 1'b0) $display("FAIL t1_capture got %b exp 0", capture); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t1_board got %h exp %h", board_out, exp_b); else n_pass++;
        n_chk++; if (next_turn !== 1'b0) $display("FAIL t1_turn got %b exp 0", next_turn); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) $display("FAIL t1_done_pulse got %b exp 0", done); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t1_board_hold got %h exp %h", board_out, exp_b); else n_pass++;
    endtask

    task automatic test_illegal_straight();
        int lat;
        run_move(init_b, 1'b1, 4'd0, 4'd5, 4'd0, 4'd4, lat);
        n_chk++; if (lat !== 5) $display("FAIL t2_latency got %0d exp 5", lat); else n_pass++;
        n_chk++; if (legal !== 1'b0) $display("FAIL t2_legal got %b exp 0", legal); else n_pass++;
        n_chk++; if (board_out !== init_b) $display("FAIL t2_board got %h exp %h", board_out, init_b); else n_pass++;
        n_chk++; if (next_turn !== 1'b1) $display("FAIL t2_turn got %b exp 1", next_turn); else n_pass++;
    endtask

    task automatic test_step_p2();
        int lat;
        logic [191:0] b, exp_b;
        exp_b = setc(setc(init_b, 1, 2, 3'b111), 0, 3, 3'b010);
        run_move(init_b, 1'b0, 4'd1, 4'd2, 4'd0, 4'd3, lat);
        n_chk++; if (legal !== 1'b1) $display("FAIL t3_legal got %b exp 1", legal); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t3_board got %h exp %h", board_out, exp_b); else n_pass++;
        n_chk++; if (next_turn !== 1'b1) $display("FAIL t3_turn got %b exp 1", next_turn); else n_pass++;
        // Backward man move onto an empty square.
        b = setc(setc('0, 1, 2, 3'b010), 0, 1, 3'b111);
        run_move(b, 1'b0, 4'd1, 4'd2, 4'd0, 4'd1, lat);
        n_chk++; if (legal !== 1'b0) $display("FAIL t3_back_legal got %b exp 0", legal); else n_pass++;
        n_chk++; if (board_out !== b) $display("FAIL t3_back_board got %h exp %h", board_out, b); else n_pass++;
        n_chk++; if (next_turn !== 1'b0) $display("FAIL t3_back_turn got %b exp 0", next_turn); else n_pass++;
    endtask

    task automatic test_jump();
        int lat;
        logic [191:0] b, exp_b;
        b = setc(setc(setc('0, 2, 4, 3'b001), 3, 3, 3'b010), 4, 2, 3'b111);
        exp_b = setc(setc(setc('0, 2, 4, 3'b111), 3, 3, 3'b111), 4, 2, 3'b001);
        run_move(b, 1'b1, 4'd2, 4'd4, 4'd4, 4'd2, lat);
        n_chk++; if (legal !== 1'b1) $display("FAIL t4_legal got %b exp 1", legal); else n_pass++;
        n_chk++; if (capture !== 1'b1) $display("FAIL t4_capture got %b exp 1", capture); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t4_board got %h exp %h", board_out, exp_b); else n_pass++;
        n_chk++; if (next_turn !== 1'b0) $display("FAIL t4_turn got %b exp 0", next_turn); else n_pass++;
        b = setc(b, 3, 3, 3'b001);
        run_move(b, 1'b1, 4'd2, 4'd4, 4'd4, 4'd2, lat);
        n_chk++; if (legal !== 1'b0) $display("FAIL t4_own_legal got %b exp 0", legal); else n_pass++;
        n_chk++; if (capture !== 1'b0) $display("FAIL t4_own_capture got %b exp 0", capture); else n_pass++;
        n_chk++; if (board_out !== b) $display("FAIL t4_own_board got %h exp %h", board_out, b); else n_pass++;
    endtask

    task automatic test_promotion_bounds();
        int lat;
        logic [191:0] b, exp_b;
        b = setc(setc('0, 1, 1, 3'b001), 0, 0, 3'b111);
        exp_b = setc(setc('0, 1, 1, 3'b111), 0, 0, 3'b101);
        run_move(b, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0, lat);
        n_chk++; if (legal !== 1'b1) $display("FAIL t5_p1prom_legal got %b exp 1", legal); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t5_p1prom_board got %h exp %h", board_out, exp_b); else n_pass++;
        b = setc(setc('0, 1, 6, 3'b010), 0, 7, 3'b111);
        exp_b = setc(setc('0, 1, 6, 3'b111), 0, 7, 3'b110);
        run_move(b, 1'b0, 4'd1, 4'd6, 4'd0, 4'd7, lat);
        n_chk++; if (board_out !== exp_b) $display("FAIL t5_p2prom_board got %h exp %h", board_out, exp_b); else n_pass++;
        // King stepping backward (toward y=7) for player 1.
        b = setc(setc('0, 3, 3, 3'b101), 4, 4, 3'b111);
        exp_b = setc(setc('0, 3, 3, 3'b111), 4, 4, 3'b101);
        run_move(b, 1'b1, 4'd3, 4'd3, 4'd4, 4'd4, lat);
        n_chk++; if (board_out !== exp_b) $display("FAIL t5_king_board got %h exp %h", board_out, exp_b); else n_pass++;
        run_move(init_b, 1'b1, 4'd0, 4'd5, 4'd9, 4'd4, lat);
        n_chk++; if (legal !== 1'b0) $display("FAIL t5_range_legal got %b exp 0", legal); else n_pass++;
        n_chk++; if (board_out !== init_b) $display("FAIL t5_range_board got %h exp %h", board_out, init_b); else n_pass++;
    endtask

    task automatic test_busy_and_abort();
        int cnt;
        int lat;
        logic [191:0] exp_b;
        exp_b = setc(setc(init_b, 0, 5, 3'b111), 1, 4, 3'b001);
        @(negedge clk);
        board_in = init_b; turn = 1'b1; x1 = 4'd0; y1 = 4'd5; x2 = 4'd1; y2 = 4'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
        end
        n_chk++; if (cnt !== 1) $display("FAIL t6_busy_dones got %0d exp 1", cnt); else n_pass++;
        // Reset asserted while the request sits in CHECK.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_chk++; if (board_out !== '0) $display("FAIL t6_abort_board got %h exp 0", board_out); else n_pass++;
        n_chk++; if (next_turn !== 1'b1) $display("FAIL t6_abort_turn got %b exp 1", next_turn); else n_pass++;
        n_chk++; if (legal !== 1'b0) $display("FAIL t6_abort_legal got %b exp 0", legal); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        n_chk++; if (cnt !== 0) $display("FAIL t6_abort_dones got %0d exp 0", cnt); else n_pass++;
        run_move(init_b, 1'b1, 4'd0, 4'd5, 4'd1, 4'd4, lat);
        n_chk++; if (lat !== 5) $display("FAIL t6_after_latency got %0d exp 5", lat); else n_pass++;
        n_chk++; if (board_out !== exp_b) $display("FAIL t6_after_board got %h exp %h", board_out, exp_b); else n_pass++;
    endtask

    initial begin
        init_b = make_init();
        test_reset();
        test_step_p1();
        test_illegal_straight();
        test_step_p2();
        test_jump();
        test_promotion_bounds();
        test_busy_and_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
